// File: rtl/qeciphy_crc8_pkg.sv
// CRC-8/SMBUS constants, step function and framer state type.
// Shared by the TX framer and the RX-side CRC checker.
package qeciphy_crc8_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic {
        PAYLOAD = 1'b0,
        CRC     = 1'b1
    } crc8_tx_state_t;

    // One byte of CRC-8/SMBUS, MSB first, no reflection.
    function automatic logic [7:0] crc8_smbus_step(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/qeciphy_crc8_frame_tx.sv
// TX framer: registers payload bytes, appends a CRC-8/SMBUS trailer byte.
// Optional QECIPHY_CRC8_TX_ERR_INJ_EN adds err_inj_i to corrupt the CRC LSB.
module qeciphy_crc8_frame_tx
    import qeciphy_crc8_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 64
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
`ifdef QECIPHY_CRC8_TX_ERR_INJ_EN
    input  logic       err_inj_i,
`endif
    input  logic [7:0] s_tdata_i,
    input  logic       s_tvalid_i,
    input  logic       s_tlast_i,
    output logic       s_tready_o,
    output logic [7:0] m_tdata_o,
    output logic       m_tvalid_o,
    output logic       m_tlast_o,
    input  logic       m_tready_i,
    output logic       trunc_o
);

    localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_BYTES);

    crc8_tx_state_t state_q;
    crc8_tx_state_t state_d;

    logic [7:0]    crc_q;
    logic [7:0]    crc_out;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          slot_free;
    logic          accept;
    logic          at_max;
    logic          frame_end;
    logic          trunc_hit;

    assign slot_free = !m_tvalid_o || m_tready_i;
    assign cnt_inc   = cnt_q + 1'b1;
    assign at_max    = (cnt_inc == CNT_MAX);

`ifdef QECIPHY_CRC8_TX_ERR_INJ_EN
    logic err_q;

    // Latch the injection request with the byte that closes the frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)       err_q <= 1'b0;
        else if (frame_end) err_q <= err_inj_i;
    end

    assign crc_out = crc_q ^ {7'b0, err_q};
`else
    assign crc_out = crc_q;
`endif

    // Handshake and frame-close decode from current state.
    always_comb begin
        s_tready_o = (state_q == PAYLOAD) && slot_free;
        accept     = s_tvalid_i && s_tready_o;
        frame_end  = accept && (s_tlast_i || at_max);
        trunc_hit  = accept && !s_tlast_i && at_max;
    end

    // Next state: close on tlast or length cap, reopen after the CRC beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PAYLOAD: if (frame_end) state_d = CRC;
            CRC:     if (slot_free) state_d = PAYLOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= PAYLOAD;
        else          state_q <= state_d;
    end

    // Output stage, running CRC and byte counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_tdata_o  <= 8'h00;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
            trunc_o    <= 1'b0;
            crc_q      <= CRC8_INIT;
            cnt_q      <= '0;
        end else begin
            trunc_o <= trunc_hit;
            unique case (state_q)
                PAYLOAD: begin
                    if (accept) begin
                        m_tdata_o  <= s_tdata_i;
                        m_tvalid_o <= 1'b1;
                        m_tlast_o  <= 1'b0;
                        crc_q      <= crc8_smbus_step(crc_q, s_tdata_i);
                        cnt_q      <= cnt_inc;
                    end else if (slot_free) begin
                        m_tvalid_o <= 1'b0;
                    end
                end
                CRC: begin
                    if (slot_free) begin
                        m_tdata_o  <= crc_out;
                        m_tvalid_o <= 1'b1;
                        m_tlast_o  <= 1'b1;
                        crc_q      <= CRC8_INIT;
                        cnt_q      <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qeciphy_crc8_frame_tx.sv
// Directed bench for qeciphy_crc8_frame_tx.
// Two instances: default length cap, and a 4-byte cap for truncation.
module tb_qeciphy_crc8_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       m_tready;
    logic       err_inj;
    logic       sel;

    logic       s_tready_a, m_tvalid_a, m_tlast_a, trunc_a;
    logic [7:0] m_tdata_a;
    logic       s_tready_b, m_tvalid_b, m_tlast_b, trunc_b;
    logic [7:0] m_tdata_b;

    qeciphy_crc8_frame_tx dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
`ifdef QECIPHY_CRC8_TX_ERR_INJ_EN
        .err_inj_i  (err_inj),
`endif
        .s_tdata_i  (s_tdata),
        .s_tvalid_i (s_tvalid),
        .s_tlast_i  (s_tlast),
        .s_tready_o (s_tready_a),
        .m_tdata_o  (m_tdata_a),
        .m_tvalid_o (m_tvalid_a),
        .m_tlast_o  (m_tlast_a),
        .m_tready_i (m_tready),
        .trunc_o    (trunc_a)
    );

    qeciphy_crc8_frame_tx #(.MAX_FRAME_BYTES(4)) dut4 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
`ifdef QECIPHY_CRC8_TX_ERR_INJ_EN
        .err_inj_i  (err_inj),
`endif
        .s_tdata_i  (s_tdata),
        .s_tvalid_i (s_tvalid),
        .s_tlast_i  (s_tlast),
        .s_tready_o (s_tready_b),
        .m_tdata_o  (m_tdata_b),
        .m_tvalid_o (m_tvalid_b),
        .m_tlast_o  (m_tlast_b),
        .m_tready_i (m_tready),
        .trunc_o    (trunc_b)
    );

    logic       s_tready, m_tvalid, m_tlast, trunc;
    logic [7:0] m_tdata;
    assign s_tready = sel ? s_tready_b : s_tready_a;
    assign m_tvalid = sel ? m_tvalid_b : m_tvalid_a;
    assign m_tlast  = sel ? m_tlast_b  : m_tlast_a;
    assign m_tdata  = sel ? m_tdata_b  : m_tdata_a;
    assign trunc    = sel ? trunc_b    : trunc_a;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int trunc_cnt = 0;
    logic [7:0] qd[$];
    logic       ql[$];
    int         qc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            qd.push_back(m_tdata);
            ql.push_back(m_tlast);
            qc.push_back(cyc);
        end
        if (trunc) trunc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        qd.delete();
        ql.delete();
        qc.delete();
        trunc_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic ok;
        int n;
        ok = 1'b0;
        n = 0;
        s_tdata = d;
        s_tlast = l;
        s_tvalid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (qd.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_beats"}, 32'(qd.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] exp_b;
        sel = 1'b0;
        m_tready = 1'b1;
        err_inj = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'h00);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_trunc", 32'(trunc), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;

        // 1) one-byte frame 0x01
        send(8'h01, 1'b1);
        chk("t1_bubble", 32'(s_tready), 32'd0);
        idle();
        wait_beats("t1", 2);
        chk("t1_d0", 32'(qd[0]), 32'h01);
        chk("t1_l0", 32'(ql[0]), 32'd0);
        chk("t1_crc", 32'(qd[1]), 32'h07);
        chk("t1_l1", 32'(ql[1]), 32'd1);
        chk("t1_gap", 32'(qc[1] - qc[0]), 32'd1);

        // 2) "123456789"
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), i == 8);
        idle();
        wait_beats("t2", 10);
        for (int i = 0; i < 9; i++) begin
            exp_b = 8'h31 + 8'(i);
            chk("t2_data", 32'(qd[i]), 32'(exp_b));
        end
        chk("t2_l8", 32'(ql[8]), 32'd0);
        chk("t2_crc", 32'(qd[9]), 32'hF4);
        chk("t2_l9", 32'(ql[9]), 32'd1);
        chk("t2_span", 32'(qc[9] - qc[0]), 32'd9);

        // 3) backpressure mid-frame
        do_reset();
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        m_tready = 1'b0;
        s_tdata = 8'h34;
        s_tvalid = 1'b1;
        s_tlast = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(m_tvalid), 32'd1);
            chk("t3_hold_data", 32'(m_tdata), 32'h33);
            chk("t3_hold_tready", 32'(s_tready), 32'd0);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        for (int i = 3; i < 9; i++) send(8'h31 + 8'(i), i == 8);
        idle();
        wait_beats("t3", 10);
        chk("t3_d2", 32'(qd[2]), 32'h33);
        chk("t3_d3", 32'(qd[3]), 32'h34);
        chk("t3_crc", 32'(qd[9]), 32'hF4);
        chk("t3_l9", 32'(ql[9]), 32'd1);

        // 4) truncation at 4 bytes, then frame {0x01, 0x00}
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h00, 1'b1);
        idle();
        wait_beats("t4", 8);
        chk("t4_l3", 32'(ql[3]), 32'd0);
        chk("t4_crc0", 32'(qd[4]), 32'h00);
        chk("t4_l4", 32'(ql[4]), 32'd1);
        chk("t4_d5", 32'(qd[5]), 32'h01);
        chk("t4_l6", 32'(ql[6]), 32'd0);
        chk("t4_crc1", 32'(qd[7]), 32'h15);
        chk("t4_l7", 32'(ql[7]), 32'd1);
        chk("t4_trunc", 32'(trunc_cnt), 32'd1);
        sel = 1'b0;

        // 5) reset mid-frame
        do_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        chk("t5_rst_valid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_data", 32'(m_tdata), 32'h00);
        chk("t5_rst_last", 32'(m_tlast), 32'd0);
        rst_n = 1'b1;
        clear_q();
        send(8'h01, 1'b1);
        idle();
        wait_beats("t5", 2);
        chk("t5_d0", 32'(qd[0]), 32'h01);
        chk("t5_crc", 32'(qd[1]), 32'h07);
        chk("t5_l1", 32'(ql[1]), 32'd1);

`ifdef QECIPHY_CRC8_TX_ERR_INJ_EN
        // 6) error injection
        do_reset();
        err_inj = 1'b1;
        send(8'h01, 1'b1);
        err_inj = 1'b0;
        idle();
        wait_beats("t6", 2);
        chk("t6_crc", 32'(qd[1]), 32'h06);
        chk("t6_l1", 32'(ql[1]), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
